// File: rtl/bitmask_index_enum_pkg.sv
// rtl/bitmask_index_enum_pkg.sv - shared types and constants for the set-bit enumerator
//
// Purpose : FSM state encoding, default mask width and index-width derivation
//           used by the interface, the top and the msb tree.
// Ports   : none (package).

package bitmask_index_enum_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ZERO = 2'd2
   } state_e;

   // Width of an index into a WIDTH-bit vector (WIDTH is a power of two >= 2).
   function automatic int idx_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bitmask_index_enum_if.sv
// rtl/bitmask_index_enum_if.sv - mask-in / index-out handshake bundle
//
// Purpose : groups the flush, input mask handshake and output index beat
//           signals of bitmask_index_enum.
// Ports   : flush, in_valid, in_ready, in_mask, out_valid, out_ready,
//           out_idx, out_last, out_none, plus out_remaining when
//           BITMASK_ENUM_COUNT_EN is defined.
// Modports: master = mask producer / index consumer, slave = the enumerator.

interface bitmask_index_enum_if
   import bitmask_index_enum_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = idx_w(WIDTH)
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mask;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_none;
`ifdef BITMASK_ENUM_COUNT_EN
   logic [IDX_W:0]   out_remaining;
`endif

   modport master (
`ifdef BITMASK_ENUM_COUNT_EN
      input  out_remaining,
`endif
      output flush, in_valid, in_mask, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_none
   );

   modport slave (
`ifdef BITMASK_ENUM_COUNT_EN
      output out_remaining,
`endif
      input  flush, in_valid, in_mask, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_none
   );

endinterface

// File: rtl/bitmask_index_enum_msb_index_tree.sv
// rtl/bitmask_index_enum_msb_index_tree.sv - log-depth highest-set-bit finder
//
// Purpose : combinational tree; each level merges pairs of (all-zero, partial
//           index) results from the level below.
// Ports   : vec_i  in  WIDTH  vector to search
//           idx_o  out IDX_W  index of highest set bit (0 when vec_i == 0)
//           zero_o out 1      vec_i is all zeros

module msb_index_tree
   import bitmask_index_enum_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             zero_o
);

   // Level l node n covers bits [n*2^l +: 2^l]; its index holds the low l bits.
   logic             z_lvl  [IDX_W+1][WIDTH];
   logic [IDX_W-1:0] ix_lvl [IDX_W+1][WIDTH];

   always_comb begin
      for (int l = 0; l <= IDX_W; l++) begin
         for (int n = 0; n < WIDTH; n++) begin
            z_lvl[l][n]  = 1'b1;
            ix_lvl[l][n] = '0;
         end
      end
      for (int n = 0; n < WIDTH; n++) begin
         z_lvl[0][n] = ~vec_i[n];
      end
      for (int l = 1; l <= IDX_W; l++) begin
         for (int n = 0; n < (WIDTH >> l); n++) begin
            z_lvl[l][n] = z_lvl[l-1][2*n] & z_lvl[l-1][2*n+1];
            // Upper half wins whenever it has any set bit.
            if (z_lvl[l-1][2*n+1]) begin
               ix_lvl[l][n] = ix_lvl[l-1][2*n];
            end else begin
               ix_lvl[l][n] = ix_lvl[l-1][2*n+1] | IDX_W'(1 << (l-1));
            end
         end
      end
   end

   assign idx_o  = ix_lvl[IDX_W][0];
   assign zero_o = z_lvl[IDX_W][0];

endmodule

// File: rtl/bitmask_index_enum.sv
// rtl/bitmask_index_enum.sv - drains a bit mask as a stream of set-bit indices
//
// Purpose : accepts a WIDTH-bit mask and emits the index of each set bit,
//           highest first, one beat per cycle. An all-zero mask yields one
//           beat flagged out_none.
// Ports   : clk  in  clock
//           rst  in  synchronous active-high reset
//           bus  slave modport of bitmask_index_enum_if (flush, in_* mask
//                handshake, out_* index beats)
// Option  : BITMASK_ENUM_COUNT_EN adds bus.out_remaining, the number of beats
//           still to come including the current one.

module bitmask_index_enum
   import bitmask_index_enum_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   bitmask_index_enum_if.slave  bus
);

   state_e           state_q;
   logic [WIDTH-1:0] rem_q;
   logic [IDX_W-1:0] msb_idx;
   logic             rem_zero;
   logic [WIDTH-1:0] rem_d;
   logic             busy;
   logic             beat_last;

   msb_index_tree #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_msb_tree (
      .vec_i  (rem_q),
      .idx_o  (msb_idx),
      .zero_o (rem_zero)
   );

   // Remaining mask once the current beat is consumed.
   assign rem_d     = rem_q & ~(WIDTH'(1) << msb_idx);
   assign busy      = (state_q == ST_BUSY) && !rem_zero;
   assign beat_last = (rem_d == '0);

   // Beat outputs depend on registers only; in_ready alone sees flush.
   assign bus.in_ready  = (state_q == ST_IDLE) && !bus.flush;
   assign bus.out_valid = busy || (state_q == ST_ZERO);
   assign bus.out_idx   = busy ? msb_idx : '0;
   assign bus.out_last  = busy ? beat_last : (state_q == ST_ZERO);
   assign bus.out_none  = (state_q == ST_ZERO);

`ifdef BITMASK_ENUM_COUNT_EN
   logic [IDX_W:0] cnt_q;
   assign bus.out_remaining = cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
`ifdef BITMASK_ENUM_COUNT_EN
         cnt_q   <= '0;
`endif
      end else if (bus.flush) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
`ifdef BITMASK_ENUM_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  if (bus.in_mask != '0) begin
                     rem_q   <= bus.in_mask;
                     state_q <= ST_BUSY;
`ifdef BITMASK_ENUM_COUNT_EN
                     cnt_q   <= (IDX_W+1)'($countones(bus.in_mask));
`endif
                  end else begin
                     state_q <= ST_ZERO;
                  end
               end
            end
            ST_BUSY: begin
               if (bus.out_ready) begin
                  rem_q <= rem_d;
`ifdef BITMASK_ENUM_COUNT_EN
                  cnt_q <= cnt_q - (IDX_W+1)'(1);
`endif
                  if (beat_last) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_ZERO: begin
               if (bus.out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               rem_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitmask_index_enum.sv
// tb/tb_bitmask_index_enum.sv - self-checking bench for bitmask_index_enum

module tb_bitmask_index_enum;

   localparam int WIDTH = 32;
   localparam int IDX_W = 5;

   typedef struct {
      int idx;
      bit last;
      bit none;
   } beat_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bitmask_index_enum_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   bitmask_index_enum #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t exp_q[$];
   int    got_q[$];
   int    want_q[$];
   int    checks   = 0;
   int    errors   = 0;
   bit    check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a mask becomes the list of its set-bit positions, highest first.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else if (bus.flush) begin
         exp_q.delete();
      end else if (exp_q.size() != 0) begin
         if (bus.out_ready) void'(exp_q.pop_front());
      end else if (bus.in_valid) begin
         if (bus.in_mask == '0) begin
            exp_q.push_back('{idx: 0, last: 1'b1, none: 1'b1});
         end else begin
            int lowest;
            lowest = -1;
            for (int i = 0; i < WIDTH && lowest < 0; i++)
               if (bus.in_mask[i]) lowest = i;
            for (int i = WIDTH - 1; i >= 0; i--)
               if (bus.in_mask[i])
                  exp_q.push_back('{idx: i, last: (i == lowest), none: 1'b0});
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         if (exp_q.size() == 0) begin
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_out_idx",   bus.out_idx,   0);
            chk("idle_out_last",  bus.out_last,  0);
            chk("idle_out_none",  bus.out_none,  0);
`ifdef BITMASK_ENUM_COUNT_EN
            chk("idle_out_remaining", bus.out_remaining, 0);
`endif
         end else begin
            chk("beat_out_valid", bus.out_valid, 1);
            chk("beat_out_idx",   bus.out_idx,   exp_q[0].idx);
            chk("beat_out_last",  bus.out_last,  exp_q[0].last);
            chk("beat_out_none",  bus.out_none,  exp_q[0].none);
`ifdef BITMASK_ENUM_COUNT_EN
            chk("beat_out_remaining", bus.out_remaining,
                exp_q[0].none ? 0 : exp_q.size());
`endif
         end
         chk("in_ready", bus.in_ready, (exp_q.size() == 0) && !bus.flush);
         if (bus.out_valid && bus.out_ready && !rst) got_q.push_back(int'(bus.out_idx));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   // Pins the delivered index sequence against hand-computed values.
   task automatic check_log(input string name);
      chk({name, "_count"}, got_q.size(), want_q.size());
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         chk({name, "_idx"}, got_q[i], want_q[i]);
      got_q.delete();
      want_q.delete();
   endtask

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mask   = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      rst      = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_in_ready",  bus.in_ready,  1);
      step();

      // Sparse mask, consumer always ready.
      got_q.delete();
      bus.in_mask   = 32'h8000_0011;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      drain("t1", 20);
      step();
      want_q = '{31, 4, 0};
      check_log("t1_beats");

      // All-zero mask.
      bus.in_mask  = 32'h0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      drain("t2", 10);
      step();
      want_q = '{0};
      check_log("t2_beats");

      // Full mask with consumer toggling.
      bus.in_mask   = 32'hFFFF_FFFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
         bus.out_ready = ~bus.out_ready;
         step();
      end
      chk("t3_drained", exp_q.size(), 0);
      bus.out_ready = 1'b1;
      step();
      for (int i = WIDTH - 1; i >= 0; i--) want_q.push_back(i);
      check_log("t3_beats");

      // Flush on the second beat.
      bus.in_mask  = 32'h0000_0F00;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      want_q = '{11, 10};
      check_log("t4_beats");

      // Reset during the third beat, then a single-bit mask.
      bus.in_mask  = 32'hAAAA_AAAA;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst          = 1'b0;
      bus.in_mask  = 32'h0000_0001;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      drain("t5", 10);
      step();
      want_q = '{31, 29, 0};
      check_log("t5_beats");

      // in_valid held with a changing mask while busy.
      bus.out_ready = 1'b0;
      bus.in_mask   = 32'h0000_00F0;
      bus.in_valid  = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         bus.in_mask = $urandom;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain("t6", 20);
      step();
      want_q = '{7, 6, 5, 4};
      check_log("t6_beats");

      // Flush in idle blocks the accept.
      bus.flush    = 1'b1;
      bus.in_mask  = 32'h0000_0005;
      bus.in_valid = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      step();
      step();
      check_log("t7_beats");

      // in_valid held high: re-accept the cycle after each last beat.
      bus.in_mask  = 32'h0000_0003;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 8; k++) step();
      bus.in_valid = 1'b0;
      drain("t8", 10);
      step();
      want_q = '{1, 0, 1, 0, 1, 0};
      check_log("t8_beats");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
